uart_debug_responder: RTL

- Host-side command engine for the pipeline debug link. Sits between the UART block's FIFO interface and the datapath.
- Pops command bytes from the RX FIFO and controls the pipeline: run, single-step, halt, pipeline reset.
- Dumps debug words plus a cycle counter back through the TX FIFO as a byte stream.

---
 rtl/uart_debug_responder_if.sv | 23 ++
 rtl/uart_debug_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_debug_responder_if.sv
// Byte FIFO handshakes (RX pop, TX push) and the debug-word read bus
// between the debug responder and the UART/datapath side.
interface uart_debug_responder_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  data_available;
  logic [7:0]            rx_data;
  logic                  read_flag;
  logic                  write_flag;
  logic [7:0]            tx_data;
  logic [ADDR_WIDTH-1:0] debug_addr;
  logic [31:0]           debug_data;

  modport master (
    input  data_available, rx_data, debug_data,
    output read_flag, write_flag, tx_data, debug_addr
  );

  modport slave (
    output data_available, rx_data, debug_data,
    input  read_flag, write_flag, tx_data, debug_addr
  );
endinterface

// File: rtl/uart_debug_responder.sv
// Debug-link command engine: pops host commands, drives pipeline run/step/halt/reset,
// and streams debug words plus the cycle counter back as bytes.
//   IDLE wait cmd | DECODE dispatch | RUN free-run | STEP one enable | RST pipe_reset
//   ACK send 'K' | ERR send '?' | DUMP_ADDR load word | DUMP_BYTE send 4 bytes | TERM send LF
module uart_debug_responder #(
  parameter int N_WORDS       = 36,
  parameter int ADDR_WIDTH    = 6,
  parameter int TX_FIFO_DEPTH = 256
) (
  input  logic                   clock,
  input  logic                   reset,
  uart_debug_responder_if.master bus,
  output logic                   pipe_enable,
  output logic                   pipe_reset,
  input  logic                   halted,
  output logic                   busy
);
  localparam int W_WIDTH = $clog2(N_WORDS + 1);

  localparam logic [7:0] CMD_RUN   = 8'h63;
  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_DUMP  = 8'h64;
  localparam logic [7:0] CMD_RESET = 8'h72;
  localparam logic [7:0] CMD_BREAK = 8'h68;

  if ((N_WORDS + 1) * 4 + 1 > TX_FIFO_DEPTH) begin : g_tx_depth_check
    $error("uart_debug_responder: one dump does not fit in the TX FIFO");
  end
  if ((2 ** ADDR_WIDTH) < N_WORDS) begin : g_addr_width_check
    $error("uart_debug_responder: ADDR_WIDTH too narrow for N_WORDS");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_RUN, S_STEP, S_RST, S_ACK, S_ERR, S_DUMP_ADDR, S_DUMP_BYTE, S_TERM
  } state_t;

  state_t                state, state_next;
  logic [7:0]            cmd;
  logic [W_WIDTH-1:0]    word_idx, word_next;
  logic [1:0]            byte_idx;
  logic [31:0]           shift_reg;
  logic [31:0]           cycle_count;
  logic [ADDR_WIDTH-1:0] debug_addr;
  logic                  read_flag;
  logic                  write_flag;
  logic [7:0]            tx_data;
  logic                  last_word;

  assign last_word      = (word_idx == W_WIDTH'(N_WORDS));
  assign busy           = (state != S_IDLE);
  assign bus.read_flag  = read_flag;
  assign bus.write_flag = write_flag;
  assign bus.tx_data    = tx_data;
  assign bus.debug_addr = debug_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    word_next   = word_idx;
    read_flag   = 1'b0;
    write_flag  = 1'b0;
    tx_data     = 8'h00;
    pipe_enable = 1'b0;
    pipe_reset  = 1'b0;
    unique case (state)
      S_IDLE: begin
        // Gated by reset so a pending RX byte cannot pop while reset is held.
        if (bus.data_available && !reset) begin
          read_flag  = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        word_next = '0;
        case (cmd)
          CMD_RUN:   state_next = S_RUN;
          CMD_STEP:  state_next = S_STEP;
          CMD_DUMP:  state_next = S_DUMP_ADDR;
          CMD_RESET: state_next = S_RST;
          default:   state_next = S_ERR;
        endcase
      end
      S_RUN: begin
        if (bus.data_available && (bus.rx_data == CMD_BREAK)) begin
          read_flag  = 1'b1;
          state_next = S_DUMP_ADDR;
        end else if (halted) begin
          state_next = S_DUMP_ADDR;
        end else begin
          pipe_enable = 1'b1;
        end
      end
      S_STEP: begin
        pipe_enable = !halted;
        state_next  = S_DUMP_ADDR;
      end
      S_RST: begin
        pipe_reset = 1'b1;
        state_next = S_ACK;
      end
      S_ACK: begin
        write_flag = 1'b1;
        tx_data    = 8'h4B;
        state_next = S_IDLE;
      end
      S_ERR: begin
        write_flag = 1'b1;
        tx_data    = 8'h3F;
        state_next = S_IDLE;
      end
      S_DUMP_ADDR: state_next = S_DUMP_BYTE;
      S_DUMP_BYTE: begin
        write_flag = 1'b1;
        tx_data    = shift_reg[31:24];
        if (byte_idx == 2'd3) begin
          if (last_word) begin
            state_next = S_TERM;
          end else begin
            word_next  = word_idx + W_WIDTH'(1);
            state_next = S_DUMP_ADDR;
          end
        end
      end
      S_TERM: begin
        write_flag = 1'b1;
        tx_data    = 8'h0A;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd         <= 8'h00;
      word_idx    <= '0;
      byte_idx    <= 2'd0;
      shift_reg   <= 32'd0;
      cycle_count <= 32'd0;
      debug_addr  <= '0;
    end else begin
      word_idx <= word_next;
      if (state == S_IDLE && read_flag) cmd <= bus.rx_data;
      if (pipe_reset)       cycle_count <= 32'd0;
      else if (pipe_enable) cycle_count <= cycle_count + 32'd1;
      // The counter slot has no debug word, so the address keeps the last real word.
      if (state_next == S_DUMP_ADDR && word_next != W_WIDTH'(N_WORDS))
        debug_addr <= ADDR_WIDTH'(word_next);
      if (state == S_DUMP_ADDR) begin
        shift_reg <= last_word ? cycle_count : bus.debug_data;
        byte_idx  <= 2'd0;
      end else if (state == S_DUMP_BYTE) begin
        shift_reg <= {shift_reg[23:0], 8'h00};
        byte_idx  <= byte_idx + 2'd1;
      end
    end
  end
endmodule
